// File: rtl/ntt_pkg.sv
// Shared types, default sizing and helper functions for the unified NTT engine.
// Latency: none (declarations and constant functions only).
// Backpressure: not applicable.
package ntt_pkg;

    typedef enum logic [1:0] {IDLE, COMPUTE, SCALE, DONE} state_t;
    typedef enum logic {FWD = 1'b0, INV = 1'b1} ntt_mode_t;

    // Default configuration and its derived schedule lengths.
    localparam int DEF_N          = 256;
    localparam int DEF_PARALLEL   = 8;
    localparam int LOGN           = $clog2(DEF_N);
    localparam int BFLY_PER_STAGE = DEF_N / 2;
    localparam int CYC_PER_STAGE  = BFLY_PER_STAGE / DEF_PARALLEL;
    localparam int SCALE_CYC      = DEF_N / DEF_PARALLEL;

    // Reverse the low 'bits' bits of v.
    function automatic int unsigned bit_reverse(input int unsigned v, input int unsigned bits);
        int unsigned r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if (i < int'(bits)) begin
                r = (r << 1) | ((v >> i) & 32'd1);
            end
        end
        return r;
    endfunction

    // Square-and-multiply b^e mod m; used at elaboration to build twiddle tables.
    function automatic longint unsigned pow_mod(input longint unsigned b, input longint unsigned e,
                                                input longint unsigned m);
        longint unsigned r;
        longint unsigned x;
        longint unsigned k;
        r = 1;
        x = b % m;
        k = e;
        for (int i = 0; i < 64; i++) begin
            if (k[0]) begin
                r = (r * x) % m;
            end
            x = (x * x) % m;
            k = k >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ntt_engine_unified_addr_gen.sv
// Butterfly address and twiddle-index generator for one cycle of PARALLEL lanes.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the addresses are used.
module ntt_addr_gen
    import ntt_pkg::*;
#(
    parameter int N          = 256,
    parameter int PARALLEL   = 8,
    parameter int ADDR_WIDTH = $clog2(N),
    parameter int SW         = $clog2($clog2(N))
) (
    input  logic [SW-1:0]                          stage,
    input  logic [ADDR_WIDTH-1:0]                  base,
    input  logic                                   mode,
    output logic [PARALLEL-1:0][ADDR_WIDTH-1:0]    addr0,
    output logic [PARALLEL-1:0][ADDR_WIDTH-1:0]    addr1,
    output logic [PARALLEL-1:0][ADDR_WIDTH-1:0]    twiddle_addr,
    output logic [PARALLEL-1:0]                    lane_valid
);
    localparam int unsigned NU = N;
    localparam int unsigned LG = $clog2(N);

    // Forward walks half from N/2 down to 1, inverse walks it from 1 up to N/2.
    always_comb begin
        int unsigned st, lh, idx, grp, k, a0;
        st = 32'(stage);
        lh = mode ? st : (LG - 32'd1 - st);
        idx = 0;
        grp = 0;
        k = 0;
        a0 = 0;
        addr0 = '0;
        addr1 = '0;
        twiddle_addr = '0;
        lane_valid = '0;
        for (int l = 0; l < PARALLEL; l++) begin
            idx = 32'(base) + 32'(l);
            grp = idx >> lh;
            a0  = (grp << (lh + 32'd1)) | (idx & ((32'd1 << lh) - 32'd1));
            k   = mode ? ((NU >> (st + 32'd1)) + grp) : ((32'd1 << st) + grp);
            addr0[l]        = ADDR_WIDTH'(a0);
            addr1[l]        = ADDR_WIDTH'(a0 + (32'd1 << lh));
            twiddle_addr[l] = ADDR_WIDTH'(bit_reverse(k, LG));
            lane_valid[l]   = (idx < NU / 32'd2);
        end
    end

endmodule

// File: rtl/ntt_engine_unified.sv
// In-place forward/inverse radix-2 NTT on one coefficient memory, optional N^-1 scaling pass.
// Latency: LOGN*(N/2)/PARALLEL compute cycles (+ N/PARALLEL when scaling); reads are 1 cycle.
// Backpressure: loads only accepted in IDLE (else load_err pulse); done held until done_ack.
module ntt_engine_unified
    import ntt_pkg::*;
#(
    parameter int N              = DEF_N,
    parameter int WIDTH          = 32,
    parameter int Q              = 8380417,
    parameter int ADDR_WIDTH     = $clog2(N),
    parameter int N_INV          = 8347681,
    parameter int PARALLEL       = DEF_PARALLEL,
    parameter int REDUCTION_TYPE = 0,
    parameter int ZETA           = 1753  // primitive 2N-th root of unity mod Q
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  mode,
    input  logic                  scale_en,
    output logic                  done,
    input  logic                  done_ack,
    output logic                  busy,
    input  logic                  load_coeff,
    input  logic [ADDR_WIDTH-1:0] load_addr,
    input  logic [WIDTH-1:0]      load_data,
    output logic                  load_err,
    input  logic [ADDR_WIDTH-1:0] read_addr,
    output logic [WIDTH-1:0]      read_data
);
    localparam int LG = $clog2(N);
    localparam int SW = $clog2(LG);
    localparam int PW = 2 * WIDTH;
    localparam int QW = $clog2(Q);
    localparam logic [PW:0] BAR_M = ((PW+1)'(1) << (2 * QW)) / (PW+1)'(Q);
    localparam logic [ADDR_WIDTH-1:0] STAGE_BASE_LAST = ADDR_WIDTH'(N / 2 - PARALLEL);
    localparam logic [ADDR_WIDTH-1:0] SCALE_BASE_LAST = ADDR_WIDTH'(N - PARALLEL);

    function automatic logic [WIDTH-1:0] mod_mult(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [PW-1:0]    p;
        logic [PW-1:0]    r;
        logic [3*WIDTH:0] qe;
        p = PW'(a) * PW'(b);
        if (REDUCTION_TYPE == 1) begin
            // Barrett: quotient estimate is short by at most two multiples of Q.
            qe = ((3*WIDTH+1)'(p) * (3*WIDTH+1)'(BAR_M)) >> (2 * QW);
            r  = p - PW'(qe) * PW'(Q);
            if (r >= PW'(Q)) r = r - PW'(Q);
            if (r >= PW'(Q)) r = r - PW'(Q);
        end else begin
            r = p % PW'(Q);
        end
        return WIDTH'(r);
    endfunction

    function automatic logic [WIDTH-1:0] add_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (WIDTH+1)'(Q)) s = s - (WIDTH+1)'(Q);
        return s[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        return (a >= b) ? (a - b) : (a + WIDTH'(Q) - b);
    endfunction

    state_t                  state_q, state_d;
    ntt_mode_t               mode_q;
    logic                    scale_q;
    logic [SW-1:0]           stage_q;
    logic [ADDR_WIDTH-1:0]   base_q;
    logic [WIDTH-1:0]        mem [N];
    logic [WIDTH-1:0]        tw_rom [N];
    logic [WIDTH-1:0]        itw_rom [N];
    logic [WIDTH-1:0]        res0 [PARALLEL];
    logic [WIDTH-1:0]        res1 [PARALLEL];
    logic [WIDTH-1:0]        sc_res [PARALLEL];
    logic [ADDR_WIDTH-1:0]   sc_addr [PARALLEL];
    logic [PARALLEL-1:0][ADDR_WIDTH-1:0] addr0, addr1, tw_addr;
    logic [PARALLEL-1:0]     lane_valid;
    logic                    last_grp;

    // Twiddle tables: forward holds zeta^i, inverse holds zeta^-i, indexed by bit-reversed k.
    for (genvar i = 0; i < N; i++) begin : g_rom
        localparam longint unsigned TW  = pow_mod(ZETA, i, Q);
        localparam longint unsigned ITW = pow_mod(ZETA, (2 * N - i) % (2 * N), Q);
        assign tw_rom[i]  = WIDTH'(TW);
        assign itw_rom[i] = WIDTH'(ITW);
    end

    ntt_addr_gen #(.N(N), .PARALLEL(PARALLEL), .ADDR_WIDTH(ADDR_WIDTH), .SW(SW)) u_addr_gen (
        .stage        (stage_q),
        .base         (base_q),
        .mode         (mode_q == INV),
        .addr0        (addr0),
        .addr1        (addr1),
        .twiddle_addr (tw_addr),
        .lane_valid   (lane_valid)
    );

    assign last_grp = (stage_q == SW'(LG - 1)) && (base_q == STAGE_BASE_LAST);
    assign busy     = (state_q == COMPUTE) || (state_q == SCALE);
    assign done     = (state_q == DONE);

    // Per-lane butterflies (CT forward, GS inverse) and scaling products.
    always_comb begin
        logic [WIDTH-1:0] a, b, w, t;
        a = '0;
        b = '0;
        w = '0;
        t = '0;
        for (int l = 0; l < PARALLEL; l++) begin
            a = mem[addr0[l]];
            b = mem[addr1[l]];
            w = (mode_q == INV) ? itw_rom[tw_addr[l]] : tw_rom[tw_addr[l]];
            if (mode_q == INV) begin
                res0[l] = add_mod(a, b);
                res1[l] = mod_mult(sub_mod(a, b), w);
            end else begin
                t       = mod_mult(w, b);
                res0[l] = add_mod(a, t);
                res1[l] = sub_mod(a, t);
            end
            sc_addr[l] = base_q + ADDR_WIDTH'(l);
            sc_res[l]  = mod_mult(mem[sc_addr[l]], WIDTH'(N_INV));
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; start and done_ack only matter in IDLE and DONE respectively.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = COMPUTE;
            COMPUTE: if (last_grp) state_d = (mode_q == INV && scale_q) ? SCALE : DONE;
            SCALE:   if (base_q == SCALE_BASE_LAST) state_d = DONE;
            DONE:    if (done_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Run configuration capture, schedule counters and the load-error pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= FWD;
            scale_q  <= 1'b0;
            stage_q  <= '0;
            base_q   <= '0;
            load_err <= 1'b0;
        end else begin
            load_err <= load_coeff && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    stage_q <= '0;
                    base_q  <= '0;
                    if (start) begin
                        mode_q  <= ntt_mode_t'(mode);
                        scale_q <= scale_en;
                    end
                end
                COMPUTE: begin
                    if (base_q == STAGE_BASE_LAST) begin
                        base_q  <= '0;
                        stage_q <= stage_q + SW'(1);
                    end else begin
                        base_q <= base_q + ADDR_WIDTH'(PARALLEL);
                    end
                end
                SCALE:   base_q <= base_q + ADDR_WIDTH'(PARALLEL);
                default: ;
            endcase
        end
    end

    // Coefficient memory: host loads in IDLE, butterfly or scale write-back during a run.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == IDLE && load_coeff) begin
                mem[load_addr] <= load_data;
            end else if (state_q == COMPUTE) begin
                for (int l = 0; l < PARALLEL; l++) begin
                    if (lane_valid[l]) begin
                        mem[addr0[l]] <= res0[l];
                        mem[addr1[l]] <= res1[l];
                    end
                end
            end else if (state_q == SCALE) begin
                for (int l = 0; l < PARALLEL; l++) begin
                    mem[sc_addr[l]] <= sc_res[l];
                end
            end
        end
    end

    // Registered read port; a same-cycle load to the same address returns the old word.
    always_ff @(posedge clk) begin
        if (rst) read_data <= '0;
        else     read_data <= mem[read_addr];
    end

endmodule

// File: tb/tb_ntt_engine_unified.sv
// Self-checking bench: vector table of transform runs, round trip, protocol and mid-run reset.
// Latency n below counts clock edges after the edge that accepts start (n=128 is "T+129").
// Read-back goes through a queue scoreboard against the 1-cycle registered read port.
`timescale 1ns/1ps
module tb_ntt_engine_unified;
    import ntt_pkg::*;

    localparam int N     = 256;
    localparam int WIDTH = 32;
    localparam int Q     = 8380417;
    localparam int AW    = 8;
    localparam int BOUND = LOGN * CYC_PER_STAGE + SCALE_CYC + 64;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0, mode = 1'b0, scale_en = 1'b0, done_ack = 1'b0;
    logic            load_coeff = 1'b0;
    logic [AW-1:0]   load_addr = '0, read_addr = '0;
    logic [WIDTH-1:0] load_data = '0;
    logic            done, busy, load_err;
    logic [WIDTH-1:0] read_data;

    always #5 clk = ~clk;

    ntt_engine_unified #(.N(N), .WIDTH(WIDTH), .Q(Q), .ADDR_WIDTH(AW), .N_INV(8347681),
                         .PARALLEL(8), .REDUCTION_TYPE(0)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .scale_en(scale_en),
        .done(done), .done_ack(done_ack), .busy(busy),
        .load_coeff(load_coeff), .load_addr(load_addr), .load_data(load_data),
        .load_err(load_err), .read_addr(read_addr), .read_data(read_data)
    );

    int n_pass = 0;
    int n_total = 0;
    logic [WIDTH-1:0] in_mem  [N];
    logic [WIDTH-1:0] exp_mem [N];
    logic [WIDTH-1:0] sb_q [$];
    int               sb_idx [$];

    typedef struct {
        logic        is_const;   // 0: value at x[0] only, 1: value everywhere
        logic [31:0] val;
        logic        m;
        logic        sc;
        int          lat;
        logic [31:0] exp0;
        logic [31:0] exp_rest;
    } vec_t;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_total++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_buf();
        for (int i = 0; i < N; i++) begin
            load_coeff = 1'b1;
            load_addr  = AW'(i);
            load_data  = in_mem[i];
            tick();
        end
        load_coeff = 1'b0;
    endtask

    task automatic run(input logic m, input logic sc, input int exp_lat, input string nm);
        int   n;
        logic prev_busy;
        start = 1'b1; mode = m; scale_en = sc;
        tick();
        start = 1'b0; mode = 1'b0; scale_en = 1'b0;
        check({nm, " busy after start"}, busy, 1);
        n = 0;
        prev_busy = busy;
        while (!done && n < BOUND) begin
            prev_busy = busy;
            tick();
            n++;
        end
        check({nm, " done latency"}, n, exp_lat);
        check({nm, " busy on last work cycle"}, prev_busy, 1);
        check({nm, " busy low at done"}, busy, 0);
    endtask

    task automatic ack(input string nm);
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check({nm, " done cleared by ack"}, done, 0);
    endtask

    task automatic dump(input string nm);
        for (int i = 0; i < N; i++) begin
            read_addr = AW'(i);
            sb_q.push_back(exp_mem[i]);
            sb_idx.push_back(i);
            tick();
            check($sformatf("%s[%0d]", nm, sb_idx.pop_front()), read_data, sb_q.pop_front());
        end
    endtask

    task automatic fill_delta(input logic [31:0] v);
        for (int i = 0; i < N; i++) in_mem[i] = (i == 0) ? v : '0;
    endtask

    initial begin
        vec_t vecs [7];
        int   n;
        vecs[0] = '{1'b0, 32'd1,          1'b0, 1'b0, 128, 32'd1,          32'd1};
        vecs[1] = '{1'b1, 32'd1,          1'b1, 1'b1, 160, 32'd1,          32'd0};
        vecs[2] = '{1'b1, 32'd1,          1'b1, 1'b0, 128, 32'd256,        32'd0};
        vecs[3] = '{1'b0, 32'd5,          1'b0, 1'b0, 128, 32'd5,          32'd5};
        vecs[4] = '{1'b1, 32'd3,          1'b1, 1'b0, 128, 32'd768,        32'd0};
        vecs[5] = '{1'b1, 32'(Q - 1),     1'b1, 1'b1, 160, 32'(Q - 1),     32'd0};
        vecs[6] = '{1'b0, 32'(Q - 1),     1'b0, 1'b0, 128, 32'(Q - 1),     32'(Q - 1)};

        // Reset values.
        tick();
        tick();
        check("reset done", done, 0);
        check("reset busy", busy, 0);
        check("reset load_err", load_err, 0);
        check("reset read_data", read_data, 0);
        rst = 1'b0;
        tick();

        // Table-driven transforms on delta / constant inputs.
        for (int v = 0; v < 7; v++) begin
            for (int i = 0; i < N; i++)
                in_mem[i] = (vecs[v].is_const || i == 0) ? vecs[v].val : '0;
            load_buf();
            check($sformatf("vec%0d load_err in IDLE", v), load_err, 0);
            run(vecs[v].m, vecs[v].sc, vecs[v].lat, $sformatf("vec%0d", v));
            ack($sformatf("vec%0d", v));
            for (int i = 0; i < N; i++) exp_mem[i] = (i == 0) ? vecs[v].exp0 : vecs[v].exp_rest;
            dump($sformatf("vec%0d", v));
        end

        // Round trip: forward, then inverse with scaling, returns the input.
        for (int i = 0; i < N; i++) in_mem[i] = $urandom_range(Q - 1, 0);
        load_buf();
        run(1'b0, 1'b0, 128, "rt fwd");
        ack("rt fwd");
        run(1'b1, 1'b1, 160, "rt inv");
        ack("rt inv");
        for (int i = 0; i < N; i++) exp_mem[i] = in_mem[i];
        dump("roundtrip");

        // Protocol: start and load while busy are ignored; done holds until ack.
        fill_delta(32'd1);
        load_buf();
        start = 1'b1; mode = 1'b0; scale_en = 1'b0;
        tick();
        start = 1'b0;
        n = 0;
        repeat (10) begin tick(); n++; end
        start = 1'b1; mode = 1'b1; scale_en = 1'b1;
        load_coeff = 1'b1; load_addr = '0; load_data = 32'd77;
        tick(); n++;
        start = 1'b0; mode = 1'b0; scale_en = 1'b0; load_coeff = 1'b0;
        check("load_err pulse while busy", load_err, 1);
        tick(); n++;
        check("load_err single cycle", load_err, 0);
        while (!done && n < BOUND) begin tick(); n++; end
        check("latency with ignored restart", n, 128);
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        check("done held without ack", done, 1);
        check("start in DONE ignored", busy, 0);
        ack("protocol");
        for (int i = 0; i < N; i++) exp_mem[i] = 32'd1;
        dump("protocol");
        done_ack = 1'b1;
        tick();
        done_ack = 1'b0;
        check("ack in IDLE no done", done, 0);
        check("ack in IDLE no busy", busy, 0);

        // Reset 50 cycles into a run, then a clean forward run.
        fill_delta(32'd1);
        load_buf();
        start = 1'b1; mode = 1'b0;
        tick();
        start = 1'b0;
        repeat (50) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid-run reset busy", busy, 0);
        check("mid-run reset done", done, 0);
        check("mid-run reset read_data", read_data, 0);
        load_buf();
        check("load accepted after reset", load_err, 0);
        run(1'b0, 1'b0, 128, "post-reset");
        ack("post-reset");
        for (int i = 0; i < N; i++) exp_mem[i] = 32'd1;
        dump("post-reset");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
